fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling FIFO between the icache fetch stage and the decoder. Buffers whole 64-bit fetch
//  packets together with their PC, exception and BTB sideband. Absorbs decode stalls so the
//  icache keeps reading, and drops all contents on a pipeline flush.
// PARAMETERS
//  ENABLE_C_EXTENSION  1  1: PC_BITS=31, IDX_BITS=2; 0: PC_BITS=30, IDX_BITS=1 (localparams)
//  DEPTH               4  entries; power of two, >=2
// PORTS
//  core_clock_i        in   1         clock, all state on rising edge
//  core_reset_ni       in   1         asynchronous active-low reset
//  core_flush_i        in   1         pipeline flush, synchronous
//  fq_vld_i            in   1         icache packet valid
//  fq_instruction_i    in   64        fetch packet
//  fq_vpc_i            in   PC_BITS   packet PC
//  fq_excp_code_i      in   4         exception code
//  fq_excp_vld_i       in   1         exception valid
//  fq_btb_index_i      in   IDX_BITS  predicted slot index
//  fq_btb_btype_i      in   2         00 cond, 01 indirect, 10 jump, 11 ret
//  fq_btb_bm_pred_i    in   2         bimodal counter
//  fq_btb_target_i     in   PC_BITS   predicted target
//  fq_btb_vld_i        in   1         BTB hit
//  fq_btb_way_i        in   1         BTB way
//  fq_busy_o           out  1         to icache busy input; high = do not present new packet
//  out_vld_o           out  1         head entry valid to decode
//  out_instruction_o   out  64        \
//  out_vpc_o .. out_btb_way_o         | same widths and meaning as the fq_*_i sideband
//  out_busy_i          in   1         decoder stall
// BEHAVIOUR
//  - Push = fq_vld_i & !fq_busy_o & !core_flush_i. Pop = out_vld_o & !out_busy_i & !core_flush_i.
//  - Pointers rd_ptr/wr_ptr are log2(DEPTH)+1 bits. The MSB disambiguates full from empty.
//    Wrap-around is the natural overflow of the pointer counters.
//  - count = wr_ptr - rd_ptr. fq_busy_o = (count==DEPTH), taken from registers only.
//    There is no combinational path from out_busy_i to fq_busy_o.
//    At full with a pop in the same cycle, fq_busy_o stays high for that cycle and deasserts
//    the next cycle.
//  - Simultaneous push and pop when not full and not empty: count is unchanged and both
//    pointers advance.
//  - out_vld_o = (count!=0). out_* = mem[rd_ptr]. Push-to-out_vld_o latency is 1 cycle.
//  - Payload travels unmodified. Exception packets (fq_excp_vld_i=1) queue like normal packets.
//  - core_flush_i: next edge sets rd_ptr = wr_ptr = 0, which makes out_vld_o=0 and
//    fq_busy_o=0. Push and pop in the flush cycle are both discarded. Storage is not cleared.
//  - Reset (async, any time including mid-transfer): pointers = 0, out_vld_o=0, fq_busy_o=0.
//    Payload outputs are don't-care while out_vld_o=0.
//  - out_* must remain stable while out_vld_o & out_busy_i (head not popped).
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined:
//   - When empty & fq_vld_i & !out_busy_i & !core_flush_i, the input drives out_*
//     combinationally with out_vld_o=1 and nothing is written.
//   - Zero-cycle latency.
//   - If empty & out_busy_i, the packet is written normally.
//  FETCHQ_BYPASS_EN undefined:
//   - Pure registered FIFO with a 1-cycle minimum latency.
//   - No path from fq_*_i to out_* within a cycle.
// STRUCTURE
//  - Package biriq_fetch_pkg:
//    - fetch_packet_t packed struct (instruction, vpc, excp_code, excp_vld, btb_index,
//      btb_btype, bm_pred, btb_target, btb_vld, btb_way), parameterised on PC_BITS/IDX_BITS
//      via localparams.
//    - btb_type_e enum {BT_COND, BT_INDIRECT, BT_JUMP, BT_RET}.
//  - Sub-module fetchq_mem: DEPTH x $bits(fetch_packet_t) array, 1 write port, async read port.
//    No reset on the array.
// TESTING
//  1. Reset, then push pkts vpc=0x100,0x104,0x108 with out_busy_i=0
//     -> out order 0x100,0x104,0x108, each 1 cycle after push (0 with BYPASS).
//  2. out_busy_i=1, push 4 pkts -> fq_busy_o=1 after 4th; 5th held by icache.
//     Release -> drain 4 in order, fq_busy_o low the cycle after first pop.
//  3. Full, out_busy_i=0 and fq_vld_i=1 same cycle
//     -> pop occurs, push rejected, next cycle push accepted; count never exceeds 4.
//  4. 3 entries queued, core_flush_i=1 with fq_vld_i=1 -> next cycle out_vld_o=0,
//     fq_busy_o=0; flushed-cycle packet absent.
//  5. Exception pkt (excp_vld=1, code=1) and BTB pkt (btype=11, target=0x2000, way=1)
//     -> emerge bit-exact.
//  6. Drop core_reset_ni mid-stream, unsynchronised to clock
//     -> out_vld_o, fq_busy_o drop immediately; queue empty after release.

Source files
------------

// File: rtl/biriq_fetch_pkg.sv
// Shared types for the fetch queue: the fetch packet layout and BTB branch-type encoding.
// Packet fields are sized for the widest configuration; narrower configs zero-extend into them.
package biriq_fetch_pkg;

    localparam int PC_BITS_MAX  = 31;
    localparam int IDX_BITS_MAX = 2;

    typedef enum logic [1:0] {
        BT_COND     = 2'b00,
        BT_INDIRECT = 2'b01,
        BT_JUMP     = 2'b10,
        BT_RET      = 2'b11
    } btb_type_e;

    typedef struct packed {
        logic [63:0]             instruction;
        logic [PC_BITS_MAX-1:0]  vpc;
        logic [3:0]              excp_code;
        logic                    excp_vld;
        logic [IDX_BITS_MAX-1:0] btb_index;
        btb_type_e               btb_btype;
        logic [1:0]              bm_pred;
        logic [PC_BITS_MAX-1:0]  btb_target;
        logic                    btb_vld;
        logic                    btb_way;
    } fetch_packet_t;

    function automatic int pc_bits(input int c_ext);
        return (c_ext != 0) ? 31 : 30;
    endfunction

    function automatic int idx_bits(input int c_ext);
        return (c_ext != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/fetchq_mem.sv
// Fetch queue storage: one synchronous write port, one asynchronous read port, no reset.
module fetchq_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between icache fetch and decode; flush empties it in one cycle.
// Define FETCHQ_BYPASS_EN for a zero-latency path from input to output while empty.
module fetch_queue
    import biriq_fetch_pkg::*;
#(
    parameter int  ENABLE_C_EXTENSION = 1,
    parameter int  DEPTH              = 4,
    localparam int PC_BITS            = pc_bits(ENABLE_C_EXTENSION),
    localparam int IDX_BITS           = idx_bits(ENABLE_C_EXTENSION)
) (
    input  logic                core_clock_i,
    input  logic                core_reset_ni,
    input  logic                core_flush_i,
    input  logic                fq_vld_i,
    input  logic [63:0]         fq_instruction_i,
    input  logic [PC_BITS-1:0]  fq_vpc_i,
    input  logic [3:0]          fq_excp_code_i,
    input  logic                fq_excp_vld_i,
    input  logic [IDX_BITS-1:0] fq_btb_index_i,
    input  logic [1:0]          fq_btb_btype_i,
    input  logic [1:0]          fq_btb_bm_pred_i,
    input  logic [PC_BITS-1:0]  fq_btb_target_i,
    input  logic                fq_btb_vld_i,
    input  logic                fq_btb_way_i,
    output logic                fq_busy_o,
    output logic                out_vld_o,
    output logic [63:0]         out_instruction_o,
    output logic [PC_BITS-1:0]  out_vpc_o,
    output logic [3:0]          out_excp_code_o,
    output logic                out_excp_vld_o,
    output logic [IDX_BITS-1:0] out_btb_index_o,
    output logic [1:0]          out_btb_btype_o,
    output logic [1:0]          out_btb_bm_pred_o,
    output logic [PC_BITS-1:0]  out_btb_target_o,
    output logic                out_btb_vld_o,
    output logic                out_btb_way_o,
    input  logic                out_busy_i
);

    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

    // Extra MSB on each pointer tells full (MSBs differ) from empty (MSBs equal).
    logic [PTR_W:0] wr_ptr, rd_ptr, count;
    logic           empty, full, bypass, push, pop;
    fetch_packet_t  in_pkt, head_pkt, out_pkt;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign fq_busy_o = full;

    always_comb begin
        in_pkt             = '0;
        in_pkt.instruction = fq_instruction_i;
        in_pkt.vpc         = PC_BITS_MAX'(fq_vpc_i);
        in_pkt.excp_code   = fq_excp_code_i;
        in_pkt.excp_vld    = fq_excp_vld_i;
        in_pkt.btb_index   = IDX_BITS_MAX'(fq_btb_index_i);
        in_pkt.btb_btype   = btb_type_e'(fq_btb_btype_i);
        in_pkt.bm_pred     = fq_btb_bm_pred_i;
        in_pkt.btb_target  = PC_BITS_MAX'(fq_btb_target_i);
        in_pkt.btb_vld     = fq_btb_vld_i;
        in_pkt.btb_way     = fq_btb_way_i;
    end

`ifdef FETCHQ_BYPASS_EN
    // A packet handed straight to an idle decoder is consumed without touching storage.
    assign bypass    = empty & fq_vld_i & ~out_busy_i & ~core_flush_i;
    assign out_pkt   = bypass ? in_pkt : head_pkt;
    assign out_vld_o = ~empty | bypass;
`else
    assign bypass    = 1'b0;
    assign out_pkt   = head_pkt;
    assign out_vld_o = ~empty;
`endif

    assign push = fq_vld_i & ~full & ~core_flush_i & ~bypass;
    assign pop  = ~empty & ~out_busy_i & ~core_flush_i;

    fetchq_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_packet_t))
    ) u_mem (
        .clk     (core_clock_i),
        .wr_en   (push),
        .wr_addr (wr_ptr[PTR_W-1:0]),
        .wr_data (in_pkt),
        .rd_addr (rd_ptr[PTR_W-1:0]),
        .rd_data (head_pkt)
    );

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (core_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign out_instruction_o = out_pkt.instruction;
    assign out_vpc_o         = out_pkt.vpc[PC_BITS-1:0];
    assign out_excp_code_o   = out_pkt.excp_code;
    assign out_excp_vld_o    = out_pkt.excp_vld;
    assign out_btb_index_o   = out_pkt.btb_index[IDX_BITS-1:0];
    assign out_btb_btype_o   = out_pkt.btb_btype;
    assign out_btb_bm_pred_o = out_pkt.bm_pred;
    assign out_btb_target_o  = out_pkt.btb_target[PC_BITS-1:0];
    assign out_btb_vld_o     = out_pkt.btb_vld;
    assign out_btb_way_o     = out_pkt.btb_way;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;

    localparam int DEPTH    = 4;
    localparam int PC_BITS  = 31;
    localparam int IDX_BITS = 2;
    localparam int W        = 64 + PC_BITS + 4 + 1 + IDX_BITS + 2 + 2 + PC_BITS + 1 + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                core_flush_i, fq_vld_i, out_busy_i;
    logic [63:0]         fq_instruction_i;
    logic [PC_BITS-1:0]  fq_vpc_i, fq_btb_target_i;
    logic [3:0]          fq_excp_code_i;
    logic                fq_excp_vld_i, fq_btb_vld_i, fq_btb_way_i;
    logic [IDX_BITS-1:0] fq_btb_index_i;
    logic [1:0]          fq_btb_btype_i, fq_btb_bm_pred_i;
    logic                fq_busy_o, out_vld_o;
    logic [63:0]         out_instruction_o;
    logic [PC_BITS-1:0]  out_vpc_o, out_btb_target_o;
    logic [3:0]          out_excp_code_o;
    logic                out_excp_vld_o, out_btb_vld_o, out_btb_way_o;
    logic [IDX_BITS-1:0] out_btb_index_o;
    logic [1:0]          out_btb_btype_o, out_btb_bm_pred_o;

    fetch_queue #(.ENABLE_C_EXTENSION(1), .DEPTH(DEPTH)) dut (
        .core_clock_i(clk), .core_reset_ni(rst_n), .core_flush_i(core_flush_i),
        .fq_vld_i(fq_vld_i), .fq_instruction_i(fq_instruction_i), .fq_vpc_i(fq_vpc_i),
        .fq_excp_code_i(fq_excp_code_i), .fq_excp_vld_i(fq_excp_vld_i),
        .fq_btb_index_i(fq_btb_index_i), .fq_btb_btype_i(fq_btb_btype_i),
        .fq_btb_bm_pred_i(fq_btb_bm_pred_i), .fq_btb_target_i(fq_btb_target_i),
        .fq_btb_vld_i(fq_btb_vld_i), .fq_btb_way_i(fq_btb_way_i), .fq_busy_o(fq_busy_o),
        .out_vld_o(out_vld_o), .out_instruction_o(out_instruction_o), .out_vpc_o(out_vpc_o),
        .out_excp_code_o(out_excp_code_o), .out_excp_vld_o(out_excp_vld_o),
        .out_btb_index_o(out_btb_index_o), .out_btb_btype_o(out_btb_btype_o),
        .out_btb_bm_pred_o(out_btb_bm_pred_o), .out_btb_target_o(out_btb_target_o),
        .out_btb_vld_o(out_btb_vld_o), .out_btb_way_o(out_btb_way_o),
        .out_busy_i(out_busy_i)
    );

    always #5 clk = ~clk;

    int             vectors = 0;
    int             errors  = 0;
    logic [W-1:0]   exp_q[$];
    logic           exp_vld, exp_busy, exp_byp, last_push;
    logic [W-1:0]   exp_pkt, cur_pkt;
    logic           cur_vld, cur_busy, cur_flush;

    function automatic logic [W-1:0] act_pkt();
        return {out_instruction_o, out_vpc_o, out_excp_code_o, out_excp_vld_o, out_btb_index_o,
                out_btb_btype_o, out_btb_bm_pred_o, out_btb_target_o, out_btb_vld_o, out_btb_way_o};
    endfunction

    function automatic logic [W-1:0] mk_pkt(input logic [63:0] instr, input logic [PC_BITS-1:0] vpc,
                                            input logic [3:0] code, input logic ev, input logic [1:0] bt,
                                            input logic [PC_BITS-1:0] tgt, input logic bv, input logic way);
        return {instr, vpc, code, ev, 2'd0, bt, 2'd0, tgt, bv, way};
    endfunction

    function automatic logic [W-1:0] rand_pkt();
        logic [W-1:0] p;
        for (int i = 0; i < W; i += 32) p[i +: 32] = $urandom();
        return p;
    endfunction

    // Apply one cycle of inputs and derive the expected outputs from the queue contents.
    task automatic drive(input logic v, input logic b, input logic f, input logic [W-1:0] p);
        cur_vld = v; cur_busy = b; cur_flush = f; cur_pkt = p;
        fq_vld_i = v; out_busy_i = b; core_flush_i = f;
        {fq_instruction_i, fq_vpc_i, fq_excp_code_i, fq_excp_vld_i, fq_btb_index_i, fq_btb_btype_i,
         fq_btb_bm_pred_i, fq_btb_target_i, fq_btb_vld_i, fq_btb_way_i} = p;
`ifdef FETCHQ_BYPASS_EN
        exp_byp = (exp_q.size() == 0) && v && !b && !f;
`else
        exp_byp = 1'b0;
`endif
        exp_vld  = (exp_q.size() != 0) || exp_byp;
        exp_busy = (exp_q.size() == DEPTH);
        exp_pkt  = exp_byp ? p : ((exp_q.size() != 0) ? exp_q[0] : '0);
    endtask

    task automatic tick();
        logic do_pop, do_push;
        @(posedge clk);
        last_push = 1'b0;
        if (cur_flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (exp_q.size() != 0) && !cur_busy;
            do_push = cur_vld && (exp_q.size() < DEPTH) && !exp_byp;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(cur_pkt);
            last_push = do_push;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_vld_o, fq_busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got vld=%b busy=%b want 0 0", out_vld_o, fq_busy_o);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 1'b0, mk_pkt(64'(i), PC_BITS'(32'h100 + 4 * i), 4'd0, 1'b0, 2'd0, '0, 1'b0, 1'b0));
            else       drive(1'b0, 1'b0, 1'b0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL order_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL order_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
`ifndef FETCHQ_BYPASS_EN
            if (i >= 1 && i <= 3) begin
                vectors++;
                if (out_vld_o !== 1'b1 || out_vpc_o !== PC_BITS'(32'h100 + 4 * (i - 1))) begin
                    errors++;
                    $display("FAIL order_latency c%0d: got vld=%b vpc=%h want 1 %h", i, out_vld_o, out_vpc_o, 32'h100 + 4 * (i - 1));
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] p;
        p = rand_pkt();
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive(1'b1, 1'b1, 1'b0, p);
            else       drive(1'b0, 1'b0, 1'b0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL fill_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL fill_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            if (i == 5) begin
                vectors++;
                if (fq_busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_busy: got %b want 1", fq_busy_o);
                end
            end
            tick();
            if (last_push) p = rand_pkt();
        end
    endtask

    task automatic test_full_pop_push();
        logic [W-1:0] p;
        p = rand_pkt();
        for (int i = 0; i < 12; i++) begin
            if (i < 4)      drive(1'b1, 1'b1, 1'b0, p);
            else if (i < 6) drive(1'b1, 1'b0, 1'b0, p);
            else            drive(1'b0, 1'b0, 1'b0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL fullpp_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL fullpp_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            if (i == 4 || i == 5) begin
                vectors++;
                if (fq_busy_o !== (i == 4)) begin
                    errors++;
                    $display("FAIL fullpp_busy c%0d: got %b want %b", i, fq_busy_o, i == 4);
                end
            end
            tick();
            if (last_push) p = rand_pkt();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            if (i < 3)       drive(1'b1, 1'b1, 1'b0, rand_pkt());
            else if (i == 3) drive(1'b1, 1'b1, 1'b1, rand_pkt());
            else             drive(1'b0, 1'b0, 1'b0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL flush_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL flush_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            if (i >= 4) begin
                vectors++;
                if ({out_vld_o, fq_busy_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL flush_empty c%0d: got vld=%b busy=%b want 0 0", i, out_vld_o, fq_busy_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_sideband();
        logic [W-1:0] pk [2];
        pk[0] = mk_pkt(64'hDEAD_BEEF_0123_4567, PC_BITS'(32'h200), 4'd1, 1'b1, 2'b00, '0, 1'b0, 1'b0);
        pk[1] = mk_pkt(64'hFEED_FACE_89AB_CDEF, PC_BITS'(32'h204), 4'd0, 1'b0, 2'b11, PC_BITS'(32'h2000), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, 1'b0, 1'b0, (i < 2) ? pk[i] : '0);
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL side_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL side_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL rand_flags c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL rand_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, rand_pkt());
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_vld_o, fq_busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_now: got vld=%b busy=%b want 0 0", out_vld_o, fq_busy_o);
        end
        exp_q.delete();
        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 1, 1'b0, 1'b0, rand_pkt());
            @(negedge clk);
            vectors++;
            if ({out_vld_o, fq_busy_o} !== {exp_vld, exp_busy}) begin
                errors++;
                $display("FAIL async_after c%0d: got vld=%b busy=%b want %b %b", i, out_vld_o, fq_busy_o, exp_vld, exp_busy);
            end
            if (exp_vld) begin
                vectors++;
                if (act_pkt() !== exp_pkt) begin
                    errors++;
                    $display("FAIL async_pkt c%0d: got %h want %h", i, act_pkt(), exp_pkt);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_drain();
        test_full_pop_push();
        test_flush();
        test_sideband();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
